acq_trigger_sequencer: RTL and testbench

Sequences LVDS sample capture into the acquisition FIFO on the clklvds domain. It replaces free-running capture with armed, threshold-triggered acquisition that keeps a configurable pre-trigger history. Configuration comes from the command processor as quasi-static registers plus an arm pulse; the block drives the FIFO write/drop strobes and reports status back.

---
 rtl/acq_trigger_sequencer_if.sv | 23 ++
 rtl/acq_trigger_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_acq_trigger_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_trigger_sequencer_if.sv
// acq_trigger_sequencer_if: sample stream in, acquisition FIFO write port out.
// master = sequencer side, slave = sample source / FIFO side.
interface acq_trigger_sequencer_if #(
  parameter int DW = 10,
  parameter int CW = 11
);
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic [CW-1:0] fifo_wrused;
  logic          fifo_wr;
  logic [DW-1:0] fifo_din;
  logic          fifo_drop;

  modport master (
    input  sample, sample_valid, fifo_wrused,
    output fifo_wr, fifo_din, fifo_drop
  );

  modport slave (
    output sample, sample_valid, fifo_wrused,
    input  fifo_wr, fifo_din, fifo_drop
  );
endinterface

// File: rtl/acq_trigger_sequencer.sv
// acq_trigger_sequencer: armed, threshold-triggered capture into the acquisition
// FIFO with a configurable pre-trigger history kept by write-and-drop while ARMED.
// Optional ARMED-timeout auto-trigger (adds the auto_trig output): ACQ_AUTOTRIG_EN.
module acq_trigger_sequencer #(
  parameter int DW        = 10,
  parameter int CW        = 11,
  parameter int FIFO_HIGH = 1020
`ifdef ACQ_AUTOTRIG_EN
  , parameter int AUTO_TIMEOUT = 1000000
`endif
) (
  input  logic          clklvds,
  input  logic          rstn,
  input  logic          arm,
  input  logic          abort,
  input  logic          force_trig,
  input  logic          trig_rising,
  input  logic [DW-1:0] threshold,
  input  logic [CW-1:0] pretrig_len,
  input  logic [CW-1:0] total_len,
  acq_trigger_sequencer_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [CW-1:0] trig_index,
  output logic [2:0]    state_o
`ifdef ACQ_AUTOTRIG_EN
  , output logic        auto_trig
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRETRIG = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] pre_reg, pre_next;
  logic [CW-1:0] post_reg, post_next;
  logic [CW-1:0] occ_reg, occ_next;
  logic [CW-1:0] rem_reg, rem_next;
  logic [CW-1:0] tidx_reg, tidx_next;
  logic [DW-1:0] din_reg, din_next;
  logic [DW-1:0] prev_reg;
  logic          wr_reg, wr_next;
  logic          drop_reg, drop_next;
  logic          done_reg, done_next;
  logic          ovf_reg, ovf_next;
  logic          armed_seen_reg;  // previous cycle was ARMED: edge detection allowed

  logic [CW-1:0] cfg_pre;
  logic          room, busy_int, arm_ok, edge_hit, auto_fire, trig, take;

  assign cfg_pre  = (pretrig_len < total_len) ? pretrig_len : total_len;
  assign room     = bus.fifo_wrused < CW'(FIFO_HIGH);
  assign take     = bus.sample_valid & room;
  assign busy_int = (state_reg == PRETRIG) || (state_reg == ARMED) || (state_reg == POST);
  assign arm_ok   = arm & ~abort & ~busy_int & (total_len != '0);
  assign edge_hit = bus.sample_valid & armed_seen_reg &
                    (trig_rising ? ((prev_reg < threshold) && (bus.sample >= threshold))
                                 : ((prev_reg > threshold) && (bus.sample <= threshold)));
  assign trig     = (state_reg == ARMED) & ~abort & (edge_hit | force_trig | auto_fire);

`ifdef ACQ_AUTOTRIG_EN
  localparam int ACW = $clog2(AUTO_TIMEOUT + 1);
  logic [ACW-1:0] acnt_reg;
  logic           auto_reg;

  assign auto_fire = (state_reg == ARMED) && (acnt_reg == ACW'(AUTO_TIMEOUT - 1));
  assign auto_trig = auto_reg;

  // count ARMED cycles; flag (sticky until next arm) when the timeout fired the trigger
  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      acnt_reg <= '0;
      auto_reg <= 1'b0;
    end else begin
      acnt_reg <= (state_reg == ARMED) ? acnt_reg + ACW'(1) : '0;
      if (arm_ok)
        auto_reg <= 1'b0;
      else if (trig && auto_fire)
        auto_reg <= 1'b1;
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  // next-state, counters and write/drop decisions for the coming cycle
  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    post_next  = post_reg;
    occ_next   = occ_reg;
    rem_next   = rem_reg;
    tidx_next  = tidx_reg;
    din_next   = din_reg;
    wr_next    = 1'b0;
    drop_next  = 1'b0;
    done_next  = done_reg;
    ovf_next   = ovf_reg;
    if (abort) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (arm_ok) begin
            pre_next   = cfg_pre;
            post_next  = total_len - cfg_pre;
            occ_next   = '0;
            done_next  = 1'b0;
            ovf_next   = 1'b0;
            state_next = (cfg_pre == '0) ? ARMED : PRETRIG;
          end
        end
        PRETRIG: begin
          if (bus.sample_valid) begin
            if (room) begin
              wr_next  = 1'b1;
              occ_next = occ_reg + CW'(1);
              if (occ_reg + CW'(1) == pre_reg)
                state_next = ARMED;
            end else begin
              ovf_next = 1'b1;
            end
          end
        end
        ARMED: begin
          // with no history to keep, only the triggering sample is ever written
          if (bus.sample_valid && !room && (trig || pre_reg != '0))
            ovf_next = 1'b1;
          if (trig) begin
            tidx_next = occ_reg;
            wr_next   = take;
            if (post_reg == '0) begin
              // nothing after the trigger: the trigger sample just rolls the history
              drop_next  = take;
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              rem_next = post_reg - CW'(take);
              if (post_reg == CW'(1) && take) begin
                state_next = DONE;
                done_next  = 1'b1;
              end else begin
                state_next = POST;
              end
            end
          end else if (pre_reg != '0) begin
            wr_next   = take;
            drop_next = take;
          end
        end
        POST: begin
          if (bus.sample_valid) begin
            if (room) begin
              wr_next  = 1'b1;
              rem_next = rem_reg - CW'(1);
              if (rem_reg == CW'(1)) begin
                state_next = DONE;
                done_next  = 1'b1;
              end
            end else begin
              ovf_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (wr_next)
      din_next = bus.sample;
  end

  // state and datapath registers
  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      pre_reg        <= '0;
      post_reg       <= '0;
      occ_reg        <= '0;
      rem_reg        <= '0;
      tidx_reg       <= '0;
      din_reg        <= '0;
      prev_reg       <= '0;
      wr_reg         <= 1'b0;
      drop_reg       <= 1'b0;
      done_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
      armed_seen_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pre_reg        <= pre_next;
      post_reg       <= post_next;
      occ_reg        <= occ_next;
      rem_reg        <= rem_next;
      tidx_reg       <= tidx_next;
      din_reg        <= din_next;
      wr_reg         <= wr_next;
      drop_reg       <= drop_next;
      done_reg       <= done_next;
      ovf_reg        <= ovf_next;
      armed_seen_reg <= (state_reg == ARMED);
      if (bus.sample_valid)
        prev_reg <= bus.sample;
    end
  end

  assign bus.fifo_wr   = wr_reg;
  assign bus.fifo_din  = din_reg;
  assign bus.fifo_drop = drop_reg;
  assign busy          = busy_int;
  assign done          = done_reg;
  assign overflow      = ovf_reg;
  assign trig_index    = tidx_reg;
  assign state_o       = state_reg;

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// tb_acq_trigger_sequencer: directed test-plan scenarios plus randomized traffic.
// A behavioural model predicts every FIFO write; a negedge monitor pops and compares.
module tb_acq_trigger_sequencer;
  localparam int DW = 10;
  localparam int CW = 11;
  localparam int FIFO_HIGH = 1020;
`ifdef ACQ_AUTOTRIG_EN
  localparam int AUTO_TIMEOUT = 50;
`endif

  logic          clklvds = 1'b0;
  logic          rstn = 1'b0;
  logic          arm = 1'b0, abort = 1'b0, force_trig = 1'b0, trig_rising = 1'b1;
  logic [DW-1:0] threshold = '0;
  logic [CW-1:0] pretrig_len = '0, total_len = '0;
  logic          busy, done, overflow;
  logic [CW-1:0] trig_index;
  logic [2:0]    state_o;
`ifdef ACQ_AUTOTRIG_EN
  logic          auto_trig;
`endif

  acq_trigger_sequencer_if #(.DW(DW), .CW(CW)) bus ();

  acq_trigger_sequencer #(
    .DW(DW), .CW(CW), .FIFO_HIGH(FIFO_HIGH)
`ifdef ACQ_AUTOTRIG_EN
    , .AUTO_TIMEOUT(AUTO_TIMEOUT)
`endif
  ) dut (
    .clklvds(clklvds), .rstn(rstn), .arm(arm), .abort(abort), .force_trig(force_trig),
    .trig_rising(trig_rising), .threshold(threshold), .pretrig_len(pretrig_len),
    .total_len(total_len), .bus(bus), .busy(busy), .done(done), .overflow(overflow),
    .trig_index(trig_index), .state_o(state_o)
`ifdef ACQ_AUTOTRIG_EN
    , .auto_trig(auto_trig)
`endif
  );

  always #5 clklvds = ~clklvds;

  // model of acquisition: phase 0 idle,1 filling history,2 waiting trigger,3 after trigger,4 done
  int  m_phase = 0, m_pre = 0, m_post = 0, m_held = 0, m_left = 0, m_prev = 0, m_tidx = 0, m_age = 0;
  bit  m_done = 0, m_ovf = 0, m_auto = 0;
  logic [DW:0] exp_q[$];          // {drop, sample}
  logic [DW:0] e_word;
  int  n_checks = 0, n_errors = 0, wr_cnt = 0, drop_cnt = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_write(int s, bit d);
    exp_q.push_back({d, DW'(s)});
  endtask

  // one clock of reference behaviour, evaluated with the inputs the DUT just sampled
  task automatic model_step();
    bit v, room, hit, autof;
    int s, thr;
    v = bus.sample_valid;
    s = int'(bus.sample);
    thr = int'(threshold);
    room = int'(bus.fifo_wrused) < FIFO_HIGH;
    autof = 0;
    if (abort) begin
      m_phase = 0;
      m_done = 0;
    end else if (m_phase == 0 || m_phase == 4) begin
      if (arm && total_len != 0) begin
        m_pre = (pretrig_len < total_len) ? int'(pretrig_len) : int'(total_len);
        m_post = int'(total_len) - m_pre;
        m_held = 0; m_done = 0; m_ovf = 0; m_auto = 0; m_age = 0;
        m_phase = (m_pre == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (v) begin
        if (room) begin
          expect_write(s, 0);
          m_held++;
          if (m_held == m_pre) begin m_phase = 2; m_age = 0; end
        end else m_ovf = 1;
      end
    end else if (m_phase == 2) begin
      hit = v && m_age > 0 && (trig_rising ? (m_prev < thr && s >= thr) : (m_prev > thr && s <= thr));
`ifdef ACQ_AUTOTRIG_EN
      autof = (m_age == AUTO_TIMEOUT - 1);
`endif
      if (hit || force_trig || autof) begin
        m_tidx = m_held;
        if (autof) m_auto = 1;
        if (v && !room) m_ovf = 1;
        if (m_post == 0) begin
          if (v && room) expect_write(s, 1);
          m_phase = 4; m_done = 1;
        end else begin
          m_left = m_post;
          if (v && room) begin expect_write(s, 0); m_left--; end
          if (m_left == 0) begin m_phase = 4; m_done = 1; end
          else m_phase = 3;
        end
      end else begin
        if (v && m_pre > 0) begin
          if (room) expect_write(s, 1);
          else m_ovf = 1;
        end
        m_age++;
      end
    end else if (m_phase == 3) begin
      if (v) begin
        if (room) begin
          expect_write(s, 0);
          m_left--;
          if (m_left == 0) begin m_phase = 4; m_done = 1; end
        end else m_ovf = 1;
      end
    end
    if (v) m_prev = s;
  endtask

  task automatic cyc(bit a, bit ab, bit f, bit v, int s, int wu);
    arm = a; abort = ab; force_trig = f;
    bus.sample_valid = v; bus.sample = DW'(s); bus.fifo_wrused = CW'(wu);
    @(posedge clklvds);
    if (rstn) model_step();
    #1;
    arm = 0; abort = 0; force_trig = 0; bus.sample_valid = 0;
  endtask

  task automatic start_scn(int pl, int tl, bit rising, int thr);
    pretrig_len = CW'(pl); total_len = CW'(tl); trig_rising = rising; threshold = DW'(thr);
    wr_cnt = 0; drop_cnt = 0;
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // monitor: status against the model every cycle, each FIFO write against the queue
  always @(negedge clklvds) begin
    chk("state", int'(state_o), m_phase);
    chk("busy", int'(busy), (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
    chk("done", int'(done), int'(m_done));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("trig_index", int'(trig_index), m_tidx);
`ifdef ACQ_AUTOTRIG_EN
    chk("auto_trig", int'(auto_trig), int'(m_auto));
`endif
    if (bus.fifo_wr) begin
      wr_cnt++;
      if (bus.fifo_drop) drop_cnt++;
      $display("wr din=%0d drop=%0d t=%0t", bus.fifo_din, bus.fifo_drop, $time);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got din=%0d drop=%0d, required no write", bus.fifo_din, bus.fifo_drop);
      end else begin
        e_word = exp_q.pop_front();
        chk("fifo_din", int'(bus.fifo_din), int'(e_word[DW-1:0]));
        chk("fifo_drop", int'(bus.fifo_drop), int'(e_word[DW]));
      end
    end else begin
      chk("drop_without_wr", int'(bus.fifo_drop), 0);
    end
  end

  initial begin
    int full_left, thr;
    bit aborted;
    bus.sample = '0; bus.sample_valid = 1'b0; bus.fifo_wrused = '0;
    idle(3);
    chk("reset_fifo_wr", int'(bus.fifo_wr), 0);
    chk("reset_state", int'(state_o), 0);
    chk("reset_done", int'(done), 0);
    rstn = 1'b1;
    idle(2);

    // 1: rising ramp, 4 history samples, 16 total
    start_scn(4, 16, 1, 512);
    for (int s = 500; s <= 530; s++) cyc(0, 0, 0, 1, s, 0);
    idle(2);
    chk("s1_done", int'(done), 1);
    chk("s1_trig_index", int'(trig_index), 4);
    chk("s1_net_writes", wr_cnt - drop_cnt, 16);

    // 2: no history, forced trigger 3 cycles after arm
    start_scn(0, 8, 1, 1000);
    for (int k = 1; k <= 15; k++) cyc(0, 0, k == 3, 1, 10 + k, 0);
    idle(2);
    chk("s2_writes", wr_cnt, 8);
    chk("s2_drops", drop_cnt, 0);
    chk("s2_trig_index", int'(trig_index), 0);

    // 3: FIFO at the high mark for 5 samples after the trigger
    start_scn(2, 10, 1, 512);
    full_left = 5;
    for (int s = 500; s <= 540; s++) begin
      if (m_phase == 3 && full_left > 0) begin
        full_left--;
        cyc(0, 0, 0, 1, s, FIFO_HIGH);
      end else cyc(0, 0, 0, 1, s, FIFO_HIGH - 1);
    end
    idle(2);
    chk("s3_overflow", int'(overflow), 1);
    chk("s3_done", int'(done), 1);
    chk("s3_net_writes", wr_cnt - drop_cnt, 10);

    // 4: abort after 3 post-trigger writes, then a clean restart
    start_scn(1, 12, 1, 512);
    aborted = 0;
    for (int s = 505; s <= 540 && !aborted; s++) begin
      if (m_phase == 3 && (m_post - m_left) == 3) begin
        cyc(0, 1, 0, 1, s, 0);
        aborted = 1;
      end else cyc(0, 0, 0, 1, s, 0);
    end
    chk("s4_busy_after_abort", int'(busy), 0);
    chk("s4_done_after_abort", int'(done), 0);
    chk("s4_state_after_abort", int'(state_o), 0);
    idle(1);
    start_scn(3, 6, 1, 700);
    for (int s = 690; s <= 710; s++) cyc(0, 0, 0, 1, s, 0);
    idle(2);
    chk("s4_restart_done", int'(done), 1);
    chk("s4_restart_net", wr_cnt - drop_cnt, 6);

    // 5: falling trigger, history longer than total -> done on the trigger sample
    start_scn(20, 10, 0, 100);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1, 200, 0);
    cyc(0, 0, 0, 1, 150, 0);
    cyc(0, 0, 0, 1, 150, 0);
    cyc(0, 0, 0, 1, 101, 0);
    cyc(0, 0, 0, 1, 100, 0);
    idle(2);
    chk("s5_done", int'(done), 1);
    chk("s5_trig_index", int'(trig_index), 10);
    chk("s5_net_writes", wr_cnt - drop_cnt, 10);

    // 6: randomized configurations and traffic
    for (int n = 0; n < 25; n++) begin
      thr = int'($urandom_range(20, 1000));
      start_scn(int'($urandom_range(0, 8)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), thr);
      for (int k = 0; k < 70; k++) begin
        int r, wu;
        r = int'($urandom_range(0, 9));
        wu = (r == 0) ? FIFO_HIGH : (r == 1) ? FIFO_HIGH - 1 : (r == 2) ? 2047 : int'($urandom_range(0, 1000));
        cyc($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) < 7, thr + int'($urandom_range(0, 12)) - 6, wu);
      end
    end

`ifdef ACQ_AUTOTRIG_EN
    // 7: flat input, trigger comes from the ARMED timeout
    cyc(0, 1, 0, 0, 0, 0);
    start_scn(2, 6, 1, 300);
    for (int k = 0; k < 70; k++) cyc(0, 0, 0, 1, 100, 0);
    idle(2);
    chk("s7_auto_trig", int'(auto_trig), 1);
    chk("s7_done", int'(done), 1);
`endif

    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
